// File: rtl/ysyx_23060332_mem_arbiter.sv
// ysyx_23060332_mem_arbiter
// Shares the single NPC memory port between IFU and LSU, one transaction at a
// time. LSU has fixed priority over IFU; a starvation counter forces an IFU
// grant after STARVE_MAX consecutive LSU grants while IFU was waiting.
// Optional response watchdog: define ARB_TIMEOUT_EN to enable it.
module ysyx_23060332_mem_arbiter #(
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_IFU  = 3'd1,
    REQ_LSU  = 3'd2,
    WAIT_IFU = 3'd3,
    WAIT_LSU = 3'd4
  } state_t;

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  state_t          state, state_nxt;
  logic [SC_W-1:0] starve_cnt, starve_cnt_nxt;
  logic            timeout;

  // State register; reset aborts any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Starvation counter, updated only by grants in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_cnt_nxt;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WC_W-1:0] wait_cnt;
  logic            arb_err_q;

  // Wait counter: held at zero during REQ so it starts from zero in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == REQ_IFU || state == REQ_LSU) begin
      wait_cnt <= '0;
    end else if (state == WAIT_IFU || state == WAIT_LSU) begin
      wait_cnt <= wait_cnt + WC_W'(1);
    end
  end

  // A real response in the last allowed cycle wins over the timeout.
  assign timeout = (state == WAIT_IFU || state == WAIT_LSU) && !mem_rsp_valid &&
                   (wait_cnt == WC_W'(TIMEOUT_CYCLES - 1));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       arb_err_q <= 1'b0;
    else if (timeout) arb_err_q <= 1'b1;
  end

  // Visible in the timeout cycle itself, then held by the flop.
  assign arb_err = arb_err_q | timeout;
`else
  // The watchdog limit has no consumer when the watchdog is absent.
  logic timeout_unused;
  assign timeout_unused = |TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign arb_err        = 1'b0;
`endif

  // Next-state, starvation update and all datapath outputs.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    ifu_req_ready  = 1'b0;
    ifu_rsp_valid  = 1'b0;
    ifu_rdata      = '0;
    lsu_req_ready  = 1'b0;
    lsu_rsp_valid  = 1'b0;
    lsu_rdata      = '0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = '0;

    case (state)
      IDLE: begin
        if (ifu_req_valid && (!lsu_req_valid || starve_cnt == SC_W'(STARVE_MAX))) begin
          state_nxt      = REQ_IFU;
          starve_cnt_nxt = '0;
        end else if (lsu_req_valid) begin
          state_nxt = REQ_LSU;
          if (ifu_req_valid && starve_cnt != SC_W'(STARVE_MAX))
            starve_cnt_nxt = starve_cnt + SC_W'(1);
        end
      end

      REQ_IFU: begin
        mem_req_valid = 1'b1;
        mem_addr      = ifu_addr;
        ifu_req_ready = mem_req_ready;
        if (mem_req_ready) begin
          if (mem_rsp_valid) begin
            ifu_rsp_valid = 1'b1;
            ifu_rdata     = mem_rdata;
            state_nxt     = IDLE;
          end else begin
            state_nxt = WAIT_IFU;
          end
        end
      end

      REQ_LSU: begin
        mem_req_valid = 1'b1;
        mem_addr      = lsu_addr;
        mem_wen       = lsu_wen;
        mem_wdata     = lsu_wdata;
        mem_wmask     = lsu_wmask;
        lsu_req_ready = mem_req_ready;
        if (mem_req_ready) begin
          if (mem_rsp_valid) begin
            lsu_rsp_valid = 1'b1;
            lsu_rdata     = mem_rdata;
            state_nxt     = IDLE;
          end else begin
            state_nxt = WAIT_LSU;
          end
        end
      end

      WAIT_IFU: begin
        if (mem_rsp_valid) begin
          ifu_rsp_valid = 1'b1;
          ifu_rdata     = mem_rdata;
          state_nxt     = IDLE;
        end else if (timeout) begin
          ifu_rsp_valid = 1'b1;
          ifu_rdata     = 32'hdeadbeef;
          state_nxt     = IDLE;
        end
      end

      WAIT_LSU: begin
        if (mem_rsp_valid) begin
          lsu_rsp_valid = 1'b1;
          lsu_rdata     = mem_rdata;
          state_nxt     = IDLE;
        end else if (timeout) begin
          lsu_rsp_valid = 1'b1;
          lsu_rdata     = 32'hdeadbeef;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Directed bench for ysyx_23060332_mem_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are sampled 2 units later.
// The watchdog scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_ysyx_23060332_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        arb_err;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060332_mem_arbiter #(
    .STARVE_MAX     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .arb_err       (arb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One flag per output; all must be zero when idle or in reset.
  function automatic logic [31:0] out_flags();
    return {20'd0, ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
            mem_req_valid, mem_wen, arb_err, |ifu_rdata, |lsu_rdata,
            |mem_addr, |mem_wdata, |mem_wmask};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; ifu_addr  = '0;
    lsu_req_valid = 1'b0; lsu_addr  = '0; lsu_wen = 1'b0;
    lsu_wdata     = '0;   lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
  endtask

  int   n_grants;
  logic accepted_prev;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    #2;
    check("reset_outputs", out_flags(), 32'h0);
    rst_n = 1'b1;

    // 1: IFU only, slave ready immediately, response one cycle later
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    #2;
    check("t1_grant_cycle_no_req", mem_req_valid, 1'b0);
    tick();
    #2;
    check("t1_mem_req_valid", mem_req_valid, 1'b1);
    check("t1_mem_addr", mem_addr, 32'h8000_0000);
    check("t1_mem_wen", mem_wen, 1'b0);
    check("t1_ifu_req_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413;
    #2;
    check("t1_ifu_rsp_valid", ifu_rsp_valid, 1'b1);
    check("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("t1_wait_no_req", mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #2;
    check("t1_back_idle", out_flags(), 32'h0);

    // 2: simultaneous IFU fetch and LSU store; LSU first
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hf; mem_req_ready = 1'b1;
    tick();
    #2;
    check("t2_lsu_ready", lsu_req_ready, 1'b1);
    check("t2_ifu_not_ready", ifu_req_ready, 1'b0);
    check("t2_mem_addr", mem_addr, 32'h8000_1000);
    check("t2_mem_wen", mem_wen, 1'b1);
    check("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    check("t2_mem_wmask", mem_wmask, 4'hf);
    tick();
    lsu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0;
    #2;
    check("t2_lsu_rsp", lsu_rsp_valid, 1'b1);
    check("t2_no_ifu_rsp", ifu_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #2;
    check("t2_ifu_arb_cycle", mem_req_valid, 1'b0);
    tick();
    #2;
    check("t2_ifu_ready", ifu_req_ready, 1'b1);
    check("t2_ifu_addr", mem_addr, 32'h8000_0004);
    check("t2_ifu_fields_zero", {27'd0, mem_wen, mem_wmask} | mem_wdata, 32'h0);
    tick();
    ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0013;
    #2;
    check("t2_ifu_rsp", ifu_rsp_valid, 1'b1);
    tick();
    mem_rsp_valid = 1'b0;

    // 3: LSU always valid, IFU waiting: expect L L L L I L L L L I
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
    lsu_wdata = '0; lsu_wmask = '0; mem_req_ready = 1'b1;
    n_grants = 0;
    accepted_prev = 1'b0;
    for (int cyc = 0; cyc < 200 && n_grants < 10; cyc++) begin
      tick();
      mem_rsp_valid = accepted_prev;
      mem_rdata     = 32'h0000_00a5;
      accepted_prev = 1'b0;
      #2;
      if (mem_req_valid && mem_req_ready) begin
        check($sformatf("t3_grant%0d_is_ifu", n_grants), ifu_req_ready,
              (n_grants % 5 == 4) ? 32'd1 : 32'd0);
        n_grants++;
        accepted_prev = 1'b1;
      end
    end
    check("t3_grant_count", n_grants, 10);
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    #2;
    check("t3_idle", out_flags(), 32'h0);

    // 4: accept and respond in the same cycle
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'hcafe_f00d;
    #2;
    check("t4_lsu_rsp", lsu_rsp_valid, 1'b1);
    check("t4_lsu_rdata", lsu_rdata, 32'hcafe_f00d);
    tick();
    lsu_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    #2;
    check("t4_idle_stray_rsp", {30'd0, lsu_rsp_valid, ifu_rsp_valid}, 32'h0);
    check("t4_idle_no_req", mem_req_valid, 1'b0);

    // 4b: response without ready in REQ is ignored
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_000c;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h2222_2222;
    #2;
    check("t4b_req_held", mem_req_valid, 1'b1);
    check("t4b_not_ready", ifu_req_ready, 1'b0);
    check("t4b_no_rsp", ifu_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    #2;
    check("t4b_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0010_0073;
    #2;
    check("t4b_rdata", ifu_rdata, 32'h0010_0073);
    tick();
    mem_rsp_valid = 1'b0;

    // 5: reset pulse during WAIT_LSU, late slave response dropped
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; mem_req_ready = 1'b1;
    tick();
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_in_reset", out_flags(), 32'h0);
    rst_n = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_5555;
    #2;
    check("t5_late_rsp_dropped", lsu_rsp_valid, 1'b0);
    check("t5_idle_outputs", out_flags(), 32'h0);
    tick();
    mem_rsp_valid = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // 6: slave never responds; timeout in the 8th WAIT cycle
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100; mem_req_ready = 1'b1;
    tick();
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b0;
    for (int w = 1; w <= 7; w++) begin
      #2;
      check($sformatf("t6_wait%0d_no_rsp", w), {30'd0, ifu_rsp_valid, arb_err}, 32'h0);
      tick();
    end
    #2;
    check("t6_timeout_rsp", ifu_rsp_valid, 1'b1);
    check("t6_timeout_rdata", ifu_rdata, 32'hdeadbeef);
    check("t6_arb_err_set", arb_err, 1'b1);
    tick();
    #2;
    check("t6_single_pulse", ifu_rsp_valid, 1'b0);
    tick(); tick();
    #2;
    check("t6_arb_err_sticky", arb_err, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_arb_err_cleared", arb_err, 1'b0);
    rst_n = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
